// File: rtl/rcswitch_send.sv
// rcswitch tri-state RF transmitter: latches a 128-bit frame (addr, chan, stat, sync)
// and shifts it out MSB-first, BIT_CLKS clocks per bit, REPEAT times back-to-back.
module rcswitch_send #(
  parameter int BIT_CLKS = 350,
  parameter int REPEAT   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic [39:0] addr,
  input  logic [39:0] chan,
  input  logic [15:0] stat,
  output logic        ready,
  output logic        done,
  output logic        out
);

  localparam int TICK_W = $clog2(BIT_CLKS);
  localparam int REP_W  = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_CLKS - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT - 1);
  localparam logic [6:0]        BIT_LAST  = 7'd127;
  localparam logic [31:0]       SYNC_WORD = 32'h8000_0000;

  typedef enum logic {IDLE, TX} state_t;

  state_t              state_q, state_d;
  logic [127:0]        frame_q, frame_d;
  logic [TICK_W-1:0]   tick_q,  tick_d;
  logic [6:0]          bit_q,   bit_d;
  logic [REP_W-1:0]    rep_q,   rep_d;
  logic                out_q,   out_d;
  logic                done_q,  done_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    out_d   = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (send) begin
          frame_d = {addr, chan, stat, SYNC_WORD};
          tick_d  = '0;
          bit_d   = '0;
          rep_d   = '0;
          out_d   = addr[39];
          state_d = TX;
        end
      end

      TX: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          bit_d  = bit_q + 7'd1;
          if (bit_q == BIT_LAST) rep_d = rep_q + 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
        // 127 - bit_cnt equals the bitwise complement for a 7-bit counter.
        out_d = frame_q[~bit_d];

        if (tick_q == TICK_LAST && bit_q == BIT_LAST && rep_q == REP_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          out_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign out   = out_q;

endmodule

// File: tb/tb_rcswitch_send.sv
// Randomized self-checking bench for rcswitch_send: three instances cover single-shot,
// repeated and loopback timings against a cycle-indexed waveform model.
module tb_rcswitch_send;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  send_v = '0;
  logic [39:0] addr = '0;
  logic [39:0] chan = '0;
  logic [15:0] stat = '0;

  logic [2:0] ready_v, done_v, out_v;

  int sel = 0;
  logic obs_ready, obs_done, obs_out;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  rcswitch_send #(.BIT_CLKS(4), .REPEAT(1)) u_rep1 (
    .clk(clk), .rst(rst), .send(send_v[0]), .addr(addr), .chan(chan), .stat(stat),
    .ready(ready_v[0]), .done(done_v[0]), .out(out_v[0]));

  rcswitch_send #(.BIT_CLKS(4), .REPEAT(3)) u_rep3 (
    .clk(clk), .rst(rst), .send(send_v[1]), .addr(addr), .chan(chan), .stat(stat),
    .ready(ready_v[1]), .done(done_v[1]), .out(out_v[1]));

  rcswitch_send #(.BIT_CLKS(10), .REPEAT(1)) u_loop (
    .clk(clk), .rst(rst), .send(send_v[2]), .addr(addr), .chan(chan), .stat(stat),
    .ready(ready_v[2]), .done(done_v[2]), .out(out_v[2]));

  always_comb begin
    obs_ready = ready_v[sel];
    obs_done  = done_v[sel];
    obs_out   = out_v[sel];
  end

  // ---------------- reference model ----------------
  function automatic logic [127:0] mk_frame(input logic [39:0] a, input logic [39:0] c,
                                            input logic [15:0] s);
    return {a, c, s, 32'h8000_0000};
  endfunction

  // Waveform k cycles after the accepting edge: bit (k / bclk) mod 128, counted from the MSB.
  function automatic logic exp_out(input logic [127:0] f, input int bclk, input int reps,
                                   input int k);
    if (k >= reps * 128 * bclk) return 1'b0;
    return f[127 - ((k / bclk) % 128)];
  endfunction

  task automatic randomize_words();
    addr = 40'({$urandom(), $urandom()});
    chan = 40'({$urandom(), $urandom()});
    stat = 16'($urandom());
  endtask

  // Raises send on a negedge and returns at the negedge after the accepting edge (k = 0).
  task automatic start_tx(input int idx);
    @(negedge clk);
    send_v[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send_v[idx] = 1'b0;
  endtask

  // Compares out/ready/done for cycles k0..k1, then advances to the negedge of k1+1.
  task automatic follow_tx(input logic [127:0] f, input int bclk, input int reps,
                           input int k0, input int k1, input string tag);
    int total;
    total = reps * 128 * bclk;
    for (int k = k0; k <= k1; k++) begin
      vectors++;
      if (obs_out !== exp_out(f, bclk, reps, k)) begin
        errors++;
        $display("FAIL %s out k=%0d: got %b expected %b", tag, k, obs_out,
                 exp_out(f, bclk, reps, k));
      end
      if (obs_ready !== (k >= total)) begin
        errors++;
        $display("FAIL %s ready k=%0d: got %b expected %b", tag, k, obs_ready, k >= total);
      end
      if (obs_done !== (k == total)) begin
        errors++;
        $display("FAIL %s done k=%0d: got %b expected %b", tag, k, obs_done, k == total);
      end
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (ready_v !== 3'b111 || done_v !== 3'b000 || out_v !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: ready=%b done=%b out=%b expected 111 000 000",
               ready_v, done_v, out_v);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [127:0] f;
    sel = 0;
    for (int n = 0; n < 3; n++) begin
      if (n == 0) begin
        addr = 40'h88_8888_8888; chan = 40'h88_8E8E_8E8E; stat = 16'h8E88;
      end else begin
        randomize_words();
      end
      f = mk_frame(addr, chan, stat);
      start_tx(0);
      follow_tx(f, 4, 1, 0, 515, "basic");
    end
  endtask

  task automatic test_repeat();
    logic [127:0] f;
    sel = 1;
    for (int n = 0; n < 2; n++) begin
      if (n == 0) begin
        addr = 40'h88_8888_8888; chan = 40'h88_8E8E_8E8E; stat = 16'h8E88;
      end else begin
        randomize_words();
      end
      f = mk_frame(addr, chan, stat);
      start_tx(1);
      follow_tx(f, 4, 3, 0, 1539, "repeat");
    end
  endtask

  task automatic test_busy_ignore();
    logic [127:0] f;
    sel = 0;
    randomize_words();
    f = mk_frame(addr, chan, stat);
    start_tx(0);
    follow_tx(f, 4, 1, 0, 99, "busy");
    send_v[0] = 1'b1;
    addr = 40'hFF_FFFF_FFFF;
    chan = ~chan;
    stat = ~stat;
    follow_tx(f, 4, 1, 100, 100, "busy");
    send_v[0] = 1'b0;
    // Long idle tail proves the ignored strobe was not queued.
    follow_tx(f, 4, 1, 101, 1100, "busy");
  endtask

  task automatic test_reset_mid_frame();
    logic [127:0] f;
    sel = 0;
    randomize_words();
    f = mk_frame(addr, chan, stat);
    start_tx(0);
    follow_tx(f, 4, 1, 0, 199, "rst_mid");
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (obs_out !== 1'b0 || obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_async: out=%b ready=%b expected 0 1", obs_out, obs_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (obs_done !== 1'b0 || obs_ready !== 1'b1 || obs_out !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_hold: done=%b ready=%b out=%b expected 0 1 0",
                 obs_done, obs_ready, obs_out);
      end
    end
    rst = 1'b1;
    randomize_words();
    f = mk_frame(addr, chan, stat);
    start_tx(0);
    follow_tx(f, 4, 1, 0, 514, "rst_restart");
  endtask

  task automatic test_back_to_back();
    logic [127:0] f1, f2;
    sel = 0;
    randomize_words();
    f1 = mk_frame(addr, chan, stat);
    @(negedge clk);
    send_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // send stays high; new words must only appear in the second transmission.
    randomize_words();
    f2 = mk_frame(addr, chan, stat);
    follow_tx(f1, 4, 1, 0, 512, "b2b_first");
    send_v[0] = 1'b0;
    follow_tx(f2, 4, 1, 0, 514, "b2b_second");
  endtask

  task automatic test_loopback();
    int exp_h[$], exp_l[$], got_h[$], got_l[$];
    int h, l;
    logic [95:0] words;
    sel = 2;
    for (int n = 0; n < 2; n++) begin
      if (n == 0) begin
        addr = 40'h88_8888_8888; chan = 40'h88_8E8E_8E8E; stat = 16'h8E88;
      end else begin
        for (int i = 0; i < 12; i++) words[i*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'h8E : 8'h88;
        {addr, chan, stat} = words;
      end
      words = {addr, chan, stat};
      exp_h.delete(); exp_l.delete(); got_h.delete(); got_l.delete();
      for (int i = 23; i >= 0; i--) begin
        if (words[i*4 +: 4] == 4'h8) begin exp_h.push_back(10); exp_l.push_back(30); end
        else                         begin exp_h.push_back(30); exp_l.push_back(10); end
      end
      exp_h.push_back(10); exp_l.push_back(310);

      start_tx(2);
      h = 0; l = 0;
      for (int k = 0; k < 1280; k++) begin
        if (obs_out === 1'b1) begin
          if (l > 0) begin got_h.push_back(h); got_l.push_back(l); h = 0; l = 0; end
          h++;
        end else begin
          l++;
        end
        @(negedge clk);
      end
      got_h.push_back(h); got_l.push_back(l);

      vectors++;
      if (obs_done !== 1'b1 || obs_out !== 1'b0) begin
        errors++;
        $display("FAIL loop_end: done=%b out=%b expected 1 0", obs_done, obs_out);
      end
      vectors++;
      if (got_h.size() != exp_h.size()) begin
        errors++;
        $display("FAIL loop_count: got %0d pulses expected %0d", got_h.size(), exp_h.size());
      end else begin
        for (int i = 0; i < exp_h.size(); i++) begin
          vectors++;
          if (got_h[i] != exp_h[i] || got_l[i] != exp_l[i]) begin
            errors++;
            $display("FAIL loop_pulse %0d: got H=%0d L=%0d expected H=%0d L=%0d",
                     i, got_h[i], got_l[i], exp_h[i], exp_l[i]);
          end
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeat();
    test_busy_ignore();
    test_reset_mid_frame();
    test_back_to_back();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
